// File: rtl/fetch_if.sv
// Fetch-stage handshake bundle: ibus request/response, execute redirect and the
// F/D buffer valid/ready interface toward decode.
//   master : fetch unit side (drives ibus request and F/D buffer outputs)
//   slave  : environment side (ibus, execute and decode)
interface fetch_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;

   modport master (
      output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
      input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
      output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Issues the ibus request for the PC held in the external
// pcreg and computes pc_nxt for it (pc_nxt = pc stalls fetch). Fetched {pc, instr}
// pairs go to decode through a one-entry F/D buffer backed by a one-entry skid.
// Execute redirects flush the buffer; a redirect that lands while a request is in
// flight waits in DISCARD until the wrong-path response drains.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   pc           current fetch PC from pcreg
//   pc_nxt       next PC back to pcreg
//   bus          fetch_if.master: ibus request/response, redirect, F/D buffer handshake
module fetch_unit #(
   parameter logic [63:0] PCINIT = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] pc,
   output logic [63:0] pc_nxt,
   fetch_if.master     bus
);

   typedef enum logic [1:0] {StReq, StDiscard, StHold} state_e;

   state_e      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_pc_q;
   logic [31:0] out_instr_q;
   logic        skid_valid_q;
   logic [63:0] skid_pc_q;
   logic [31:0] skid_instr_q;
   logic [63:0] pend_pc_q, pend_pc_d;

   logic buf_free;
   logic load_resp;   // buffer <= {pc, iresp_data}
   logic load_skid;   // buffer <= skid
   logic fill_skid;   // skid <= {pc, iresp_data}
   logic clr_skid;

   assign buf_free       = !out_valid_q || bus.out_ready;
   assign bus.ireq_valid = !reset && (state_q == StReq || state_q == StDiscard);
   assign bus.ireq_addr  = pc;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_pc     = out_pc_q;
   assign bus.out_instr  = out_instr_q;

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      pc_nxt    = pc;
      load_resp = 1'b0;
      load_skid = 1'b0;
      fill_skid = 1'b0;
      clr_skid  = 1'b0;

      if (!reset) begin
         unique case (state_q)
            StReq: begin
               if (bus.redirect_valid && bus.iresp_data_ok) begin
                  pc_nxt = bus.redirect_pc;
               end else if (bus.redirect_valid) begin
                  // Request must stay on the bus until its response; remember the target.
                  pend_pc_d = bus.redirect_pc;
                  state_d   = StDiscard;
               end else if (bus.iresp_data_ok && buf_free) begin
                  load_resp = 1'b1;
                  pc_nxt    = pc + 64'd4;
               end else if (bus.iresp_data_ok) begin
                  fill_skid = 1'b1;
                  pc_nxt    = pc + 64'd4;
                  state_d   = StHold;
               end
            end
            StDiscard: begin
               if (bus.redirect_valid) begin
                  pend_pc_d = bus.redirect_pc;
               end
               if (bus.iresp_data_ok) begin
                  pc_nxt  = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
                  state_d = StReq;
               end
            end
            StHold: begin
               if (bus.redirect_valid) begin
                  clr_skid = 1'b1;
                  pc_nxt   = bus.redirect_pc;
                  state_d  = StReq;
               end else if (bus.out_ready) begin
                  load_skid = 1'b1;
                  clr_skid  = 1'b1;
                  state_d   = StReq;
               end
            end
            default: state_d = StReq;
         endcase
      end

      // Flush wins over any load and over a decode transfer.
      out_valid_d = out_valid_q;
      if (bus.redirect_valid) begin
         out_valid_d = 1'b0;
      end else if (load_resp || load_skid) begin
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StReq;
         out_valid_q  <= 1'b0;
         out_pc_q     <= PCINIT;
         out_instr_q  <= 32'd0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= PCINIT;
         skid_instr_q <= 32'd0;
         pend_pc_q    <= 64'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         pend_pc_q   <= pend_pc_d;
         if (load_resp) begin
            out_pc_q    <= pc;
            out_instr_q <= bus.iresp_data;
         end else if (load_skid) begin
            out_pc_q    <= skid_pc_q;
            out_instr_q <= skid_instr_q;
         end
         if (fill_skid) begin
            skid_valid_q <= 1'b1;
            skid_pc_q    <= pc;
            skid_instr_q <= bus.iresp_data;
         end else if (clr_skid) begin
            skid_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   localparam logic [63:0] PCINIT = 64'h8000_0000;

   logic        clk;
   logic        reset;
   logic [63:0] pc;
   logic [63:0] pc_nxt;
   int          n_cmp;
   int          n_err;

   fetch_if bus ();

   fetch_unit #(.PCINIT(PCINIT)) dut (
      .clk    (clk),
      .reset  (reset),
      .pc     (pc),
      .pc_nxt (pc_nxt),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pcreg model: no enable, reset to PCINIT.
   always_ff @(posedge clk) begin
      if (reset) pc <= PCINIT;
      else       pc <= pc_nxt;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iresp_data_ok  = 1'b0;
      bus.iresp_data     = 32'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'd0;
      bus.out_ready      = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      next();
      next();
      reset = 1'b0;
   endtask

   task automatic resp(input logic [31:0] d);
      bus.iresp_data_ok = 1'b1;
      bus.iresp_data    = d;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      idle_inputs();
      next();
      next();
      // Still in reset
      chk("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_pc_nxt", pc_nxt, PCINIT);
      reset = 1'b0;
      #1;
      chk("t1_first_valid", {63'd0, bus.ireq_valid}, 64'd1);
      chk("t1_addr0", bus.ireq_addr, 64'h8000_0000);

      // Test 1: back-to-back fetch
      resp(32'h1111_1111);
      #1;
      chk("t1_pc_nxt0", pc_nxt, 64'h8000_0004);
      next();
      resp(32'h2222_2222);
      #1;
      chk("t1_addr1", bus.ireq_addr, 64'h8000_0004);
      chk("t1_ov1", {63'd0, bus.out_valid}, 64'd1);
      chk("t1_opc1", bus.out_pc, 64'h8000_0000);
      chk("t1_oin1", {32'd0, bus.out_instr}, 64'h1111_1111);
      next();
      resp(32'h3333_3333);
      #1;
      chk("t1_addr2", bus.ireq_addr, 64'h8000_0008);
      chk("t1_ov2", {63'd0, bus.out_valid}, 64'd1);
      chk("t1_opc2", bus.out_pc, 64'h8000_0004);
      chk("t1_oin2", {32'd0, bus.out_instr}, 64'h2222_2222);
      next();
      bus.iresp_data_ok = 1'b0;
      #1;
      chk("t1_ov3", {63'd0, bus.out_valid}, 64'd1);
      chk("t1_opc3", bus.out_pc, 64'h8000_0008);
      chk("t1_oin3", {32'd0, bus.out_instr}, 64'h3333_3333);

      // Test 2: backpressure into skid, HOLD, release
      do_reset();
      resp(32'hA000_0000);
      next();
      bus.out_ready = 1'b0;
      resp(32'hA000_0004);
      #1;
      chk("t2_pc_nxt_skid", pc_nxt, 64'h8000_0008);
      next();
      bus.iresp_data_ok = 1'b0;
      #1;
      chk("t2_hold_ireq", {63'd0, bus.ireq_valid}, 64'd0);
      chk("t2_hold_pc", pc, 64'h8000_0008);
      chk("t2_hold_pc_nxt", pc_nxt, 64'h8000_0008);
      chk("t2_hold_opc", bus.out_pc, 64'h8000_0000);
      bus.out_ready = 1'b1;
      next();
      #1;
      chk("t2_rel_ov", {63'd0, bus.out_valid}, 64'd1);
      chk("t2_rel_opc", bus.out_pc, 64'h8000_0004);
      chk("t2_rel_oin", {32'd0, bus.out_instr}, 64'hA000_0004);
      chk("t2_rel_ireq", {63'd0, bus.ireq_valid}, 64'd1);
      chk("t2_rel_addr", bus.ireq_addr, 64'h8000_0008);

      // Test 3: redirect with request in flight
      do_reset();
      resp(32'hB000_0000);
      next();
      bus.iresp_data_ok = 1'b0;
      next();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_1000;
      #1;
      chk("t3_redir_pc_nxt", pc_nxt, 64'h8000_0004);
      next();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t3_disc_addr", bus.ireq_addr, 64'h8000_0004);
      chk("t3_disc_ireq", {63'd0, bus.ireq_valid}, 64'd1);
      chk("t3_disc_ov", {63'd0, bus.out_valid}, 64'd0);
      next();
      chk("t3_disc_addr2", bus.ireq_addr, 64'h8000_0004);
      next();
      resp(32'hDEAD_BEEF);
      #1;
      chk("t3_drain_pc_nxt", pc_nxt, 64'h8000_1000);
      next();
      bus.iresp_data_ok = 1'b0;
      #1;
      chk("t3_drop_ov", {63'd0, bus.out_valid}, 64'd0);
      chk("t3_new_addr", bus.ireq_addr, 64'h8000_1000);

      // Test 4: redirect coincident with data_ok (buffer holds a valid instr)
      resp(32'hC000_0000);
      next();
      chk("t4_ov_before", {63'd0, bus.out_valid}, 64'd1);
      resp(32'hC000_0004);
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_2000;
      #1;
      chk("t4_pc_nxt", pc_nxt, 64'h8000_2000);
      next();
      bus.redirect_valid = 1'b0;
      bus.iresp_data_ok  = 1'b0;
      bus.out_ready      = 1'b1;
      #1;
      chk("t4_ov_flush", {63'd0, bus.out_valid}, 64'd0);
      chk("t4_addr", bus.ireq_addr, 64'h8000_2000);

      // Test 5: two redirects while discarding, latest wins
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h100;
      next();
      bus.redirect_pc = 64'h200;
      #1;
      chk("t5_disc_addr", bus.ireq_addr, 64'h8000_2000);
      next();
      bus.redirect_valid = 1'b0;
      resp(32'h5555_5555);
      #1;
      chk("t5_pc_nxt", pc_nxt, 64'h200);
      next();
      bus.iresp_data_ok = 1'b0;
      #1;
      chk("t5_addr", bus.ireq_addr, 64'h200);
      chk("t5_ov", {63'd0, bus.out_valid}, 64'd0);

      // Test 6: redirect in HOLD, then reset mid-request
      do_reset();
      resp(32'hD000_0000);
      next();
      bus.out_ready = 1'b0;
      resp(32'hD000_0004);
      next();
      bus.iresp_data_ok  = 1'b0;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h8000_3000;
      #1;
      chk("t6_hold_ireq", {63'd0, bus.ireq_valid}, 64'd0);
      chk("t6_pc_nxt", pc_nxt, 64'h8000_3000);
      next();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t6_ov", {63'd0, bus.out_valid}, 64'd0);
      chk("t6_ireq", {63'd0, bus.ireq_valid}, 64'd1);
      chk("t6_addr", bus.ireq_addr, 64'h8000_3000);
      next();
      // Skid must not replay D000_0004
      chk("t6_skid_clr_ov", {63'd0, bus.out_valid}, 64'd0);
      resp(32'hE000_0000);
      next();
      bus.iresp_data_ok = 1'b0;
      chk("t6_ov_loaded", {63'd0, bus.out_valid}, 64'd1);
      chk("t6_opc_loaded", bus.out_pc, 64'h8000_3000);
      bus.out_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_rst_ireq", {63'd0, bus.ireq_valid}, 64'd0);
      chk("t6_rst_pc_nxt", pc_nxt, 64'h8000_3004);
      next();
      chk("t6_rst_ov", {63'd0, bus.out_valid}, 64'd0);
      reset = 1'b0;
      #1;
      chk("t6_post_addr", bus.ireq_addr, PCINIT);
      chk("t6_post_ireq", {63'd0, bus.ireq_valid}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
